// File: rtl/utopia_tx_cell_scheduler.sv
// utopia_tx_cell_scheduler: round-robin arbiter feeding one Utopia ATM transmitter with held 53-byte cells.
// Optional UTOPIA_TX_SCHED_HEC_EN regenerates the HEC byte at capture.
module utopia_tx_cell_scheduler #(
  parameter int NumSrc = 4,
  parameter int SrcW   = $clog2(NumSrc)
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic [NumSrc-1:0]     src_valid,
  input  logic [NumSrc*424-1:0] src_cell,
  output logic [NumSrc-1:0]     src_ack,
  input  logic [NumSrc-1:0]     cfg_mask,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [423:0]          tx_cell,
  output logic [SrcW-1:0]       tx_src,
  output logic [15:0]           cell_count,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, ACCEPT, SENDING, COMPLETE} state_t;
  state_t state_q, state_d;
  logic [NumSrc-1:0] ack_q, ack_d, elig;
  logic tx_valid_q, tx_valid_d, found;
  logic [423:0] cell_q, cell_d, win_cell, cap_cell;
  logic [SrcW-1:0] src_q, src_d, last_q, last_d, win, idx;
  logic [15:0] count_q, count_d;
`ifdef UTOPIA_TX_SCHED_HEC_EN
  function automatic logic [7:0] crc8(input logic [31:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 31; i >= 0; i--) c = {c[6:0], 1'b0} ^ ((c[7] ^ d[i]) ? 8'h07 : 8'h00);
    return c;
  endfunction
`endif
  assign elig = src_valid & cfg_mask;
  always_comb begin
    win = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 1; k <= NumSrc; k++) begin
      idx = SrcW'((int'(last_q) + k) % NumSrc);
      if (!found && elig[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    win_cell = '0;
    for (int i = 0; i < NumSrc; i++) if (win == SrcW'(i)) win_cell = src_cell[i*424 +: 424];
  end
`ifdef UTOPIA_TX_SCHED_HEC_EN
  assign cap_cell = {win_cell[423:392], crc8(win_cell[423:392]) ^ 8'h55, win_cell[383:0]};
`else
  assign cap_cell = win_cell;
`endif
  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    tx_valid_d = tx_valid_q;
    cell_d     = cell_q;
    src_d      = src_q;
    last_d     = last_q;
    count_d    = count_q;
    case (state_q)
      IDLE: if (tx_ready && found) begin
        cell_d      = cap_cell;
        src_d       = win;
        last_d      = win;
        ack_d[win]  = 1'b1;
        tx_valid_d  = 1'b1;
        state_d     = ACCEPT;
      end
      ACCEPT: if (!tx_ready) begin
        tx_valid_d = 1'b0;
        state_d    = SENDING;
      end
      SENDING: if (tx_ready) begin
        count_d = count_q + 16'd1;
        state_d = COMPLETE;
      end
      default: state_d = tx_ready ? COMPLETE : IDLE;
    endcase
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      tx_valid_q <= 1'b0;
      cell_q     <= '0;
      src_q      <= '0;
      last_q     <= SrcW'(NumSrc - 1);
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      tx_valid_q <= tx_valid_d;
      cell_q     <= cell_d;
      src_q      <= src_d;
      last_q     <= last_d;
      count_q    <= count_d;
    end
  end
  assign src_ack    = ack_q;
  assign tx_valid   = tx_valid_q;
  assign tx_cell    = cell_q;
  assign tx_src     = src_q;
  assign cell_count = count_q;
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_utopia_tx_cell_scheduler.sv
// tb_utopia_tx_cell_scheduler: scoreboard bench; stimulus queues expected captures, a monitor checks each ack.
module tb_utopia_tx_cell_scheduler;
  localparam int N = 4;
  logic clk_in = 1'b0, reset = 1'b1, tx_ready = 1'b0;
  logic [N-1:0] src_valid = '0, cfg_mask = '0, src_ack;
  logic [N*424-1:0] src_cell = '0;
  logic tx_valid, busy;
  logic [423:0] tx_cell, hold_exp = '0;
  logic [1:0] tx_src;
  logic [15:0] cell_count;
  bit hold_chk = 1'b0;
  int checks = 0, errors = 0;
  typedef struct {logic [1:0] s; logic [423:0] c;} exp_t;
  exp_t sb[$];
  utopia_tx_cell_scheduler #(.NumSrc(N)) dut (
    .clk_in(clk_in), .reset(reset), .src_valid(src_valid), .src_cell(src_cell),
    .src_ack(src_ack), .cfg_mask(cfg_mask), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_cell(tx_cell), .tx_src(tx_src), .cell_count(cell_count), .busy(busy)
  );
  always #5 clk_in = ~clk_in;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [423:0] mk(input int s, input int n);
    logic [423:0] c;
    for (int b = 0; b < 53; b++) c[423-8*b -: 8] = 8'(s * 16 + n + b * 3 + 1);
    return c;
  endfunction
`ifdef UTOPIA_TX_SCHED_HEC_EN
  function automatic logic [7:0] crc8(input logic [31:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 31; i >= 0; i--) c = (c[7] ^ d[i]) ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    return c;
  endfunction
`endif
  function automatic logic [423:0] exp_cell(input logic [423:0] c);
    logic [423:0] r;
    r = c;
`ifdef UTOPIA_TX_SCHED_HEC_EN
    r[391:384] = crc8(c[423:392]) ^ 8'h55;
`endif
    return r;
  endfunction
  task automatic push(input int s);
    exp_t e;
    e.s = 2'(s);
    e.c = exp_cell(src_cell[s*424 +: 424]);
    sb.push_back(e);
  endtask
  always @(negedge clk_in) if (!reset) begin
    if (|src_ack) begin
      exp_t e;
      chk("ack_onehot", 64'($countones(src_ack)), 64'd1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got %b expected none", src_ack);
      end else begin
        e = sb.pop_front();
        chk("ack_src", 64'(src_ack), 64'(4'b0001 << e.s));
        chk("tx_src", 64'(tx_src), 64'(e.s));
        chk("tx_valid_at_capture", 64'(tx_valid), 64'd1);
        checks++;
        if (tx_cell !== e.c) begin
          errors++;
          $display("FAIL tx_cell: got %h expected %h", tx_cell, e.c);
        end
      end
    end
    if (hold_chk && busy) begin
      checks++;
      if (tx_cell !== hold_exp) begin
        errors++;
        $display("FAIL tx_cell_hold: got %h expected %h", tx_cell, hold_exp);
      end
    end
  end
  task automatic wait_valid();
    int t;
    t = 0;
    while (!tx_valid && t < 50) begin
      @(posedge clk_in);
      #1;
      t++;
    end
    chk("tx_valid_timeout", 64'(tx_valid), 64'd1);
  endtask
  task automatic xfer(input bit mutate);
    tx_ready = 1'b1;
    wait_valid();
    @(posedge clk_in);
    #1;
    if (mutate) src_cell[2*424 +: 424] = ~src_cell[2*424 +: 424];
    tx_ready = 1'b0;
    @(posedge clk_in);
    #1;
    repeat (3) @(posedge clk_in);
    #1;
    tx_ready = 1'b1;
    @(posedge clk_in);
    #1;
    tx_ready = 1'b0;
    @(posedge clk_in);
    #1;
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk_in);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < N; i++) src_cell[i*424 +: 424] = mk(i, 0);
    repeat (2) @(posedge clk_in);
    #1;
    reset = 1'b0;
    chk("rst_tx_valid", 64'(tx_valid), 64'd0);
    chk("rst_src_ack", 64'(src_ack), 64'd0);
    chk("rst_tx_cell_lo", 64'(tx_cell[63:0]), 64'd0);
    chk("rst_tx_src", 64'(tx_src), 64'd0);
    chk("rst_cell_count", 64'(cell_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    cfg_mask = 4'hF;
    src_valid = 4'b0001;
    push(0);
    xfer(1'b0);
    chk("single_count", 64'(cell_count), 64'd1);
    chk("single_idle", 64'(busy), 64'd0);
    pulse_reset();
    src_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      push(k % 4);
      xfer(1'b0);
    end
    chk("rr_count", 64'(cell_count), 64'd8);
    cfg_mask = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      push((k % 2 == 0) ? 1 : 3);
      xfer(1'b0);
    end
    chk("mask_count", 64'(cell_count), 64'd12);
    cfg_mask = 4'h0;
    tx_ready = 1'b1;
    repeat (6) begin
      @(posedge clk_in);
      #1;
      chk("mask0_busy", 64'(busy), 64'd0);
      chk("mask0_tx_valid", 64'(tx_valid), 64'd0);
    end
    cfg_mask = 4'b0100;
    src_cell[2*424 +: 424] = mk(2, 7);
    hold_exp = exp_cell(mk(2, 7));
    hold_chk = 1'b1;
    push(2);
    xfer(1'b1);
    hold_chk = 1'b0;
    chk("hold_after_complete", 64'(tx_cell[63:0]), hold_exp[63:0]);
    chk("hold_count", 64'(cell_count), 64'd13);
    cfg_mask = 4'hF;
    src_valid = 4'b1000;
    push(3);
    tx_ready = 1'b1;
    wait_valid();
    @(posedge clk_in);
    #1;
    tx_ready = 1'b0;
    @(posedge clk_in);
    #1;
    chk("sending_tx_valid", 64'(tx_valid), 64'd0);
    chk("sending_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_tx_valid", 64'(tx_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ack", 64'(src_ack), 64'd0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    src_valid = 4'hF;
    push(0);
    xfer(1'b0);
    pulse_reset();
    src_valid = 4'b0001;
    src_cell[423:0] = {32'h0, 8'hAA, {48{8'h5A}}};
    begin
      exp_t e;
      e.s = 2'd0;
`ifdef UTOPIA_TX_SCHED_HEC_EN
      e.c = {32'h0, 8'h55, {48{8'h5A}}};
`else
      e.c = {32'h0, 8'hAA, {48{8'h5A}}};
`endif
      sb.push_back(e);
    end
    xfer(1'b0);
`ifdef UTOPIA_TX_SCHED_HEC_EN
    chk("hec_byte", 64'(tx_cell[391:384]), 64'h55);
`else
    chk("hec_byte", 64'(tx_cell[391:384]), 64'hAA);
`endif
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
